// File: rtl/fc_layer_mac.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_mac
// Purpose  : Time-multiplexed fully-connected layer. Buffers a streamed input
//            vector, then computes OUT_CH neurons one after another with LANES
//            multipliers per cycle, rounding, bias add, optional ReLU and
//            saturation, and streams each result out over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fc_layer_mac #(
    parameter int IN_CH      = 120,
    parameter int OUT_CH     = 84,
    parameter int IN_BITS    = 16,
    parameter int W_BITS     = 8,
    parameter int BIAS_BITS  = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 12,
    parameter int LANES      = 4,
    parameter int RELU       = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    s_valid,
    input  logic [$clog2(IN_CH)-1:0]                s_ch_idx,
    input  logic [IN_BITS-1:0]                      s_pix,
    input  logic                                    s_vec_valid,
    output logic                                    s_ready,
    output logic                                    w_rd_en,
    output logic [$clog2(OUT_CH*(IN_CH/LANES))-1:0] w_addr,
    input  logic [LANES*W_BITS-1:0]                 w_rdata,
    output logic [$clog2(OUT_CH)-1:0]               b_addr,
    input  logic [BIAS_BITS-1:0]                    b_rdata,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [$clog2(OUT_CH)-1:0]               m_idx,
    output logic [OUT_WIDTH-1:0]                    m_data,
    output logic                                    busy,
    output logic                                    err_overrun
);

    localparam int STEPS  = IN_CH / LANES;
    localparam int ACC_W  = IN_BITS + W_BITS + $clog2(IN_CH) + 1;
    localparam int CH_W   = $clog2(IN_CH);
    localparam int AW     = $clog2(OUT_CH * STEPS);
    localparam int NW     = $clog2(OUT_CH);
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_POST = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [STEP_W-1:0]        r_step;
    logic [STEP_W-1:0]        r_step_d;
    logic [NW-1:0]            r_neuron;
    logic signed [ACC_W-1:0]  r_acc;
    logic [IN_BITS-1:0]       r_ibuf [IN_CH];
    logic [IN_BITS-1:0]       r_abuf [IN_CH];

    logic                     w_ch_ok;
    logic                     w_step_last;
    logic                     w_neuron_last;
    logic [CH_W-1:0]          w_idx;
    logic signed [ACC_W-1:0]  w_pa;
    logic signed [ACC_W-1:0]  w_pw;
    logic signed [ACC_W-1:0]  w_lane_sum;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_shr;
    logic signed [ACC_W-1:0]  w_res;
    logic signed [ACC_W-1:0]  w_sat;

    assign w_ch_ok       = ({1'b0, s_ch_idx} < (CH_W+1)'(IN_CH));
    assign w_step_last   = (r_step == STEP_W'(STEPS - 1));
    assign w_neuron_last = (r_neuron == NW'(OUT_CH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (s_vec_valid) w_state_nxt = S_MAC;
            S_MAC:   if (w_step_last) w_state_nxt = S_POST;
            S_POST:  w_state_nxt = S_OUT;
            S_OUT:   if (m_ready) w_state_nxt = w_neuron_last ? S_IDLE : S_MAC;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; the weight address walks n*STEPS+s only while reading
    always_comb begin
        s_ready = (r_state == S_IDLE);
        busy    = (r_state != S_IDLE);
        w_rd_en = (r_state == S_MAC);
        m_valid = (r_state == S_OUT);
        w_addr  = '0;
        if (r_state == S_MAC)
            w_addr = AW'(int'(r_neuron) * STEPS + int'(r_step));
        b_addr  = r_neuron;
    end

    // Input buffer takes writes in any state; work buffer snapshots it on a start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < IN_CH; i++) begin
                r_ibuf[i] <= '0;
                r_abuf[i] <= '0;
            end
        end else begin
            if (s_valid && w_ch_ok)
                r_ibuf[s_ch_idx] <= s_pix;
            if (r_state == S_IDLE && s_vec_valid) begin
                for (int i = 0; i < IN_CH; i++) begin
                    if (s_valid && w_ch_ok && s_ch_idx == CH_W'(i))
                        r_abuf[i] <= s_pix;
                    else
                        r_abuf[i] <= r_ibuf[i];
                end
            end
        end
    end

    // Dot product of the lane group whose weights arrive this cycle
    always_comb begin
        w_lane_sum = '0;
        w_idx      = '0;
        w_pa       = '0;
        w_pw       = '0;
        for (int j = 0; j < LANES; j++) begin
            w_idx = CH_W'(int'(r_step_d) * LANES + j);
            w_pa  = {{(ACC_W-IN_BITS){r_abuf[w_idx][IN_BITS-1]}}, r_abuf[w_idx]};
            w_pw  = {{(ACC_W-W_BITS){w_rdata[j*W_BITS+W_BITS-1]}},
                     w_rdata[j*W_BITS +: W_BITS]};
            w_lane_sum = w_lane_sum + w_pa * w_pw;
        end
    end

    // Final accumulate, round half-up, bias add, ReLU and saturation
    always_comb begin
        w_sum = r_acc + w_lane_sum;
        w_shr = (w_sum + ROUND_C) >>> FRAC_SHIFT;
        w_res = w_shr + {{(ACC_W-BIAS_BITS){b_rdata[BIAS_BITS-1]}}, b_rdata};
        if (RELU != 0 && w_res[ACC_W-1])
            w_res = '0;
        if (w_res > SAT_MAX)      w_sat = SAT_MAX;
        else if (w_res < SAT_MIN) w_sat = SAT_MIN;
        else                      w_sat = w_res;
    end

    // Step/neuron counters, accumulator and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step   <= '0;
            r_step_d <= '0;
            r_neuron <= '0;
            r_acc    <= '0;
            m_idx    <= '0;
            m_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_vec_valid) begin
                        r_step   <= '0;
                        r_neuron <= '0;
                    end
                end
                S_MAC: begin
                    r_step_d <= r_step;
                    r_acc    <= (r_step == '0) ? '0 : (r_acc + w_lane_sum);
                    if (!w_step_last)
                        r_step <= r_step + 1'b1;
                end
                S_POST: begin
                    m_data <= w_sat[OUT_WIDTH-1:0];
                    m_idx  <= r_neuron;
                end
                default: begin
                    if (m_ready) begin
                        r_step   <= '0;
                        r_neuron <= w_neuron_last ? '0 : (r_neuron + 1'b1);
                    end
                end
            endcase
        end
    end

    // Sticky flag for a vector start that arrives while a run is in progress
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_overrun <= 1'b0;
        else if (s_vec_valid && r_state != S_IDLE)
            err_overrun <= 1'b1;
    end

endmodule
`default_nettype wire
